// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory: FSM encoding, NOP word,
// default geometry and the even-parity helper used when INSTR_MEM_PARITY_EN is defined.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [15:0] NOP_WORD      = 16'h0000;
    localparam int          DEFAULT_DEPTH = 256;
    localparam int          DEFAULT_AW    = 8;

    // Parity bit that makes the total number of ones in {bit, word} even.
    function automatic logic even_parity(input logic [15:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x W storage with one synchronous write port and one synchronous read port.
// The read register can be cleared, or loaded with zero for out-of-range fetches.
module instr_mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int W     = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic          zero,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // Program-load write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Fetch read register: holds its value when no fetch is issued.
    always_ff @(posedge clk) begin
        if (clr) begin
            rdata <= {W{1'b0}};
        end else if (re) begin
            rdata <= zero ? {W{1'b0}} : mem_r[raddr];
        end
    end

endmodule

// File: rtl/instr_mem.sv
// Instruction memory with program-load port: IDLE/LOAD/RUN FSM, load pointer and
// out-of-range check. Optional parity storage/check under macro INSTR_MEM_PARITY_EN.
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        rd,
    output logic [15:0] instr,
    output logic        valid,
    output logic        oob,
    input  logic        ld_start,
    input  logic        ld_wr,
    input  logic [15:0] ld_data,
    input  logic        ld_done,
    output logic        busy,
    output logic        ld_ovf,
`ifdef INSTR_MEM_PARITY_EN
    output logic        par_err,
`endif
    output logic [AW:0] ld_count
);

`ifdef INSTR_MEM_PARITY_EN
    localparam int W = 17;
`else
    localparam int W = 16;
`endif

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

    state_e      state_r;
    logic        valid_r;
    logic        oob_r;
    logic        busy_r;
    logic        ld_ovf_r;
    logic [AW:0] ld_count_r;

    logic         addr_oob_s;
    logic         we_s;
    logic         fetch_s;
    logic [W-1:0] wdata_s;
    logic [W-1:0] rdata_s;

    // Any address bit above the decoded range means out of range; no aliasing.
    generate
        if (AW < 16) begin : g_oob
            assign addr_oob_s = |addr[15:AW];
        end else begin : g_no_oob
            assign addr_oob_s = 1'b0;
        end
    endgenerate

    assign we_s    = !reset && (state_r == LOAD) && !ld_start && ld_wr && (ld_count_r < FULL_COUNT);
    assign fetch_s = !reset && (state_r == RUN) && !ld_start && rd;

`ifdef INSTR_MEM_PARITY_EN
    assign wdata_s = {even_parity(ld_data), ld_data};
`else
    assign wdata_s = ld_data;
`endif

    instr_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (W)
    ) u_array (
        .clk   (clk),
        .clr   (reset),
        .we    (we_s),
        .waddr (ld_count_r[AW-1:0]),
        .wdata (wdata_s),
        .re    (fetch_s),
        .zero  (addr_oob_s),
        .raddr (addr[AW-1:0]),
        .rdata (rdata_s)
    );

    // Control FSM: load pointer, overflow flag and fetch status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            valid_r    <= 1'b0;
            oob_r      <= 1'b0;
            busy_r     <= 1'b0;
            ld_ovf_r   <= 1'b0;
            ld_count_r <= {(AW+1){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (ld_start) begin
                        state_r    <= LOAD;
                        busy_r     <= 1'b1;
                        ld_ovf_r   <= 1'b0;
                        ld_count_r <= {(AW+1){1'b0}};
                    end
                end
                LOAD: begin
                    valid_r <= 1'b0;
                    if (ld_start) begin
                        ld_ovf_r   <= 1'b0;
                        ld_count_r <= {(AW+1){1'b0}};
                    end else begin
                        // A write in the same cycle as ld_done still lands.
                        if (ld_wr) begin
                            if (ld_count_r < FULL_COUNT) begin
                                ld_count_r <= ld_count_r + ONE_COUNT;
                            end else begin
                                ld_ovf_r <= 1'b1;
                            end
                        end
                        if (ld_done) begin
                            state_r <= RUN;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (ld_start) begin
                        state_r    <= LOAD;
                        busy_r     <= 1'b1;
                        valid_r    <= 1'b0;
                        ld_ovf_r   <= 1'b0;
                        ld_count_r <= {(AW+1){1'b0}};
                    end else if (rd) begin
                        valid_r <= 1'b1;
                        oob_r   <= addr_oob_s;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign valid    = valid_r;
    assign oob      = oob_r;
    assign busy     = busy_r;
    assign ld_ovf   = ld_ovf_r;
    assign ld_count = ld_count_r;

`ifdef INSTR_MEM_PARITY_EN
    assign par_err = valid_r && (even_parity(rdata_s[15:0]) != rdata_s[16]);
    assign instr   = par_err ? NOP_WORD : rdata_s[15:0];
`else
    assign instr   = rdata_s;
`endif

endmodule

// File: tb/tb_instr_mem.sv
// Directed self-checking bench for instr_mem (default DEPTH=256, AW=8).
module tb_instr_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic        rd;
    logic [15:0] instr;
    logic        valid;
    logic        oob;
    logic        ld_start;
    logic        ld_wr;
    logic [15:0] ld_data;
    logic        ld_done;
    logic        busy;
    logic        ld_ovf;
    logic [8:0]  ld_count;
`ifdef INSTR_MEM_PARITY_EN
    logic        par_err;
`endif

    int tests = 0;
    int fails = 0;

    instr_mem dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .rd       (rd),
        .instr    (instr),
        .valid    (valid),
        .oob      (oob),
        .ld_start (ld_start),
        .ld_wr    (ld_wr),
        .ld_data  (ld_data),
        .ld_done  (ld_done),
        .busy     (busy),
        .ld_ovf   (ld_ovf),
`ifdef INSTR_MEM_PARITY_EN
        .par_err  (par_err),
`endif
        .ld_count (ld_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [15:0] a);
        addr = a;
        rd   = 1'b1;
        tick();
        rd   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; addr = 16'h0000; rd = 1'b0;
        ld_start = 1'b0; ld_wr = 1'b0; ld_data = 16'h0000; ld_done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_instr", instr, 17'h0);
        check("rst_valid", valid, 17'h0);
        check("rst_oob", oob, 17'h0);
        check("rst_busy", busy, 17'h0);
        check("rst_ovf", ld_ovf, 17'h0);
        check("rst_count", ld_count, 17'h0);

        // rd in IDLE is ignored
        fetch(16'h0000);
        check("idle_rd_valid", valid, 17'h0);

        // Basic load of three words, with a stray rd during LOAD
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        check("load_busy", busy, 17'h1);
        ld_wr = 1'b1;
        ld_data = 16'h0010; tick();
        ld_data = 16'hEC10; rd = 1'b1; tick(); rd = 1'b0;
        check("load_rd_valid", valid, 17'h0);
        ld_data = 16'h0003; tick();
        ld_wr = 1'b0;
        ld_done = 1'b1; tick(); ld_done = 1'b0;
        check("run_busy", busy, 17'h0);

        fetch(16'h0001);
        check("f1_instr", instr, 17'hEC10);
        check("f1_valid", valid, 17'h1);
        check("f1_count", ld_count, 17'd3);

        // PC-style back-to-back fetches
        addr = 16'h0000; rd = 1'b1; tick();
        check("seq0_instr", instr, 17'h0010);
        check("seq0_valid", valid, 17'h1);
        addr = 16'h0001; tick();
        check("seq1_instr", instr, 17'hEC10);
        check("seq1_valid", valid, 17'h1);
        addr = 16'h0002; tick();
        check("seq2_instr", instr, 17'h0003);
        check("seq2_valid", valid, 17'h1);
        rd = 1'b0; addr = 16'h0001; tick();
        check("idle_valid", valid, 17'h0);
        check("hold_instr", instr, 17'h0003);

        // Out-of-range fetches
        fetch(16'h0100);
        check("oob_instr", instr, 17'h0);
        check("oob_flag", oob, 17'h1);
        check("oob_valid", valid, 17'h1);
        fetch(16'h0000);
        check("inr_oob", oob, 17'h0);
        check("inr_instr", instr, 17'h0010);
        fetch(16'h8001);
        check("oob_hi_instr", instr, 17'h0);
        check("oob_hi_flag", oob, 17'h1);

        // Overflow: words 1..257 carry 16'h2000+k, word 257 is dropped
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        ld_wr = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            ld_data = 16'h2000 + 16'(k);
            tick();
        end
        check("full_count", ld_count, 17'd256);
        check("full_ovf", ld_ovf, 17'h0);
        ld_data = 16'h2101; tick();
        ld_wr = 1'b0;
        check("ovf_count", ld_count, 17'd256);
        check("ovf_flag", ld_ovf, 17'h1);
        ld_done = 1'b1; tick(); ld_done = 1'b0;
        check("ovf_sticky", ld_ovf, 17'h1);
        fetch(16'h00FF);
        check("ovf_last", instr, 17'h2100);
        fetch(16'h0000);
        check("ovf_first", instr, 17'h2001);

        // ld_start beats rd in RUN; ld_wr together with ld_done
        addr = 16'h0001; rd = 1'b1; ld_start = 1'b1; tick();
        rd = 1'b0; ld_start = 1'b0;
        check("prio_valid", valid, 17'h0);
        check("prio_busy", busy, 17'h1);
        check("reload_ovf", ld_ovf, 17'h0);
        check("reload_count", ld_count, 17'd0);
        ld_wr = 1'b1; ld_done = 1'b1; ld_data = 16'hAAAA; tick();
        ld_wr = 1'b0; ld_done = 1'b0;
        check("wrdone_busy", busy, 17'h0);
        check("wrdone_count", ld_count, 17'd1);
        fetch(16'h0000);
        check("wrdone_instr", instr, 17'hAAAA);

        // Reset mid-load keeps already-written words
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        ld_wr = 1'b1;
        ld_data = 16'h1111; tick();
        ld_data = 16'h2222; tick();
        ld_wr = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_busy", busy, 17'h0);
        check("mid_rst_count", ld_count, 17'd0);
        check("mid_rst_valid", valid, 17'h0);
        check("mid_rst_instr", instr, 17'h0);
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        ld_wr = 1'b1; ld_data = 16'h5555; tick(); ld_wr = 1'b0;
        ld_done = 1'b1; tick(); ld_done = 1'b0;
        fetch(16'h0001);
        check("keep_word1", instr, 17'h2222);
        fetch(16'h0000);
        check("new_word0", instr, 17'h5555);

        // ld_wr / ld_done outside LOAD are ignored
        ld_wr = 1'b1; ld_done = 1'b1; ld_data = 16'hFFFF; tick();
        ld_wr = 1'b0; ld_done = 1'b0;
        check("run_wr_count", ld_count, 17'd1);
        fetch(16'h0000);
        check("run_wr_instr", instr, 17'h5555);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
